ex_muldiv_stage: RTL and testbench
==================================

# ex_muldiv_stage

Parametrised execute stage for the static 5-stage pipeline. It generalises the ALU execute stage with internal forwarding logic, where MEM has priority over WB and register 0 is never forwarded. It adds a multi-cycle iterative multiply/divide unit with architectural HI/LO registers, MFHI/MFLO/MTHI/MTLO support, and a stall output to the hazard unit. It sits between the ID/EX and EX/MEM pipeline registers.

## Interface
Parameters:
- DATA_W, 32, datapath width; must be even and at least 8.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high.
- RegDst_ex, ALUSrcA_ex, ALUSrcB_ex  in  1 each  destination-register and operand selects. Same meaning as the single-cycle ALU execute stage.
- ALUCode_ex  in  5  ALU operation code.
- Imm_ex, Sa_ex  in  DATA_W each  extended immediate and shift amount.
- RsAddr_ex, RtAddr_ex, RdAddr_ex  in  REG_AW each  source and destination register addresses.
- RsData_ex, RtData_ex  in  DATA_W each  register-file read data.
- ALUResult_mem, RegWriteData_wb  in  DATA_W each  forwarding sources.
- RegWriteAddr_mem, RegWriteAddr_wb  in  REG_AW each  forwarding destination addresses.
- RegWrite_mem, RegWrite_wb  in  1 each  forwarding write enables.
- MdStart_ex  in  1  EX holds MULT, MULTU, DIV or DIVU.
- MdOp_ex  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- HiLoRead_ex  in  2  result select: 01 MFHI, 10 MFLO, others select the ALU.
- HiLoWrite_ex  in  2  write select: 01 MTHI, 10 MTLO; the written value is forwarded Rs.
- RegWriteAddr_ex  out  REG_AW  equals Rd when RegDst_ex is 1, otherwise Rt.
- ALUResult_ex  out  DATA_W  ALU result, HI or LO.
- MemWriteData_ex  out  DATA_W  forwarded Rt value.
- ALU_A, ALU_B  out  DATA_W  ALU operands after the source muxes.
- Stall_ex  out  1  freezes PC, IF/ID and ID/EX, and inserts a bubble into EX/MEM.
- Hi, Lo  out  DATA_W each  architectural HI and LO registers.

## Operation
Forwarding:
- ForwardA selects ALUResult_mem when RegWrite_mem is 1, RegWriteAddr_mem is nonzero and RegWriteAddr_mem equals RsAddr_ex.
- Otherwise it selects RegWriteData_wb when the same three conditions hold for the WB stage.
- Otherwise it selects RsData_ex. ForwardB applies the same rules using RtAddr_ex.

Hazard op:
- A hazard op is MdStart_ex, or any nonzero HiLoRead_ex, or any nonzero HiLoWrite_ex.
- Stall_ex = hazard op AND (state != IDLE). It is purely combinational.

FSM states: IDLE, BUSY, DONE.
- IDLE to BUSY when MdStart_ex is 1.
  - Latch forwarded A and B, op, sign flags, and the operand magnitudes (magnitudes only for signed ops).
  - Set cnt = DATA_W.
- BUSY: one iteration per cycle, then cnt decrements.
  - Multiply: shift-add over a 2*DATA_W accumulator.
  - Divide: restoring; remainder/quotient shift-subtract.
  - Move to DONE when cnt reaches 1.
- DONE: apply sign fix-up and load HI/LO, then go to IDLE.
  - Product: negated when the signs differ. HI gets the upper DATA_W bits, LO the lower.
  - Quotient: negated when the signs differ. LO gets the quotient.
  - Remainder: takes the dividend's sign. HI gets the remainder.
- Divide by zero: HI = the dividend as given, LO = all ones. No sign fix-up is applied.
- Signed minimum divided by −1: LO = 0x8000_0000, HI = 0. This is the natural wrap; no trap.
- MTHI/MTLO in IDLE writes forwarded A into HI or LO at the clock edge.
- MFHI/MFLO in IDLE returns the registered HI or LO value.
- Only IDLE accepts hazard ops. A start, move or read arriving in BUSY or DONE stalls until the block returns to IDLE.
- Reset at any time, including mid-operation:
  - state goes to IDLE, and HI, LO, cnt and the accumulators clear to 0.
  - Stall_ex is 0 in the following cycle.

## Timing
- The forwarding, ALU, ALU_A, ALU_B, MemWriteData_ex and RegWriteAddr_ex paths are combinational, with zero latency.
- If MdStart_ex is sampled in IDLE at edge T:
  - BUSY occupies cycles T+1 through T+DATA_W.
  - DONE occurs in cycle T+DATA_W+1.
  - HI/LO update at the end of that cycle.
  - IDLE is reached at T+DATA_W+2.
- The start instruction itself never stalls.
- An MFHI issued right after MULT stalls for DATA_W+1 cycles. It then reads the new value.
- Reset values: Hi = 0, Lo = 0, Stall_ex = 0, state = IDLE.

## Structure
- Shared package: MdOp encodings, HiLoRead/HiLoWrite encodings, FSM state encodings, and the existing ALUCode constants.
- Reuse the existing combinational ALU instance.
- Sub-module muldiv_iter, parametrised by DATA_W:
  - Contains the FSM, the counter, the iteration datapath, sign fix-up, and HI/LO.
  - The top level handles the forwarding muxes, operand muxes, result mux and stall logic.

## Test plan
- Forwarding: MEM writes r5 = 0x11 and WB writes r5 = 0x22 while EX reads r5 → A = 0x11. With the address set to r0 → A = RsData_ex.
- MULT −3 × 7 → stall begins after the start. Then HI = 0xFFFF_FFFF, LO = 0xFFFF_FFEB, and MFHI stalls exactly 33 cycles.
- DIV −7 ÷ 2 → LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF. DIVU 7 ÷ 0 → LO = 0xFFFF_FFFF, HI = 7.
- DIV 0x8000_0000 ÷ −1 → LO = 0x8000_0000, HI = 0. MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → HI = 0xFFFF_FFFE, LO = 1.
- MTLO with forwarded 0xABCD arriving during BUSY → it stalls until IDLE, and the new LO (0xABCD) overwrites the multiply result.
- Reset asserted at cycle 10 of a DIV → next cycle: Stall_ex = 0, Hi = Lo = 0, and a new MULT 2 × 3 gives LO = 6.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// +--------------------------------------------------------------------------+
// | ex_muldiv_pkg : shared encodings for the EX stage and mul/div unit  r1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

package ex_muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam logic [1:0] HILO_HI = 2'b01;
  localparam logic [1:0] HILO_LO = 2'b10;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_NOR  = 5'd5;
  localparam logic [4:0] ALU_SLT  = 5'd6;
  localparam logic [4:0] ALU_SLTU = 5'd7;
  localparam logic [4:0] ALU_SLL  = 5'd8;
  localparam logic [4:0] ALU_SRL  = 5'd9;
  localparam logic [4:0] ALU_SRA  = 5'd10;
  localparam logic [4:0] ALU_LUI  = 5'd11;

  function automatic logic md_is_signed(input md_op_e op);
    return ~op[0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_alu.sv
// +--------------------------------------------------------------------------+
// | ex_alu : combinational ALU; shifts take B by the low bits of A      r1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

module ex_alu
  import ex_muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [4:0]        code_i,
  output logic [DATA_W-1:0] result_o
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] shamt;
  assign shamt = a_i[SH_W-1:0];

  always_comb begin
    result_o = '0;
    case (code_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_NOR:  result_o = ~(a_i | b_i);
      ALU_SLT:  result_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: result_o = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
      ALU_SLL:  result_o = b_i << shamt;
      ALU_SRL:  result_o = b_i >> shamt;
      ALU_SRA:  result_o = $signed(b_i) >>> shamt;
      ALU_LUI:  result_o = {b_i[DATA_W/2-1:0], {(DATA_W/2){1'b0}}};
      default:  result_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ex_muldiv_stage_muldiv_iter.sv
// +--------------------------------------------------------------------------+
// | muldiv_iter : iterative shift-add multiply / restoring divide, HI/LO r1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

module muldiv_iter
  import ex_muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  md_op_e            op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              hi_we_i,
  input  logic              lo_we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  md_state_e             state_q, state_d;
  logic [2*DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]     a_q, a_d, mag_b_q, mag_b_d, hi_q, hi_d, lo_q, lo_d;
  logic                  sa_q, sa_d, sb_q, sb_d, is_div_q, is_div_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  sa, sb;
  logic [DATA_W-1:0]     mag_a, mag_b;
  logic [DATA_W:0]       mul_sum, div_shift, div_sub;
  logic                  div_ge;
  logic [2*DATA_W-1:0]   mul_next, div_next;

  assign sa    = md_is_signed(op_i) & a_i[DATA_W-1];
  assign sb    = md_is_signed(op_i) & b_i[DATA_W-1];
  assign mag_a = sa ? -a_i : a_i;
  assign mag_b = sb ? -b_i : b_i;

  // Accumulator holds {partial product | multiplier} or {remainder | dividend/quotient}.
  assign mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
                   + ({1'b0, mag_b_q} & {(DATA_W+1){acc_q[0]}});
  assign mul_next  = {mul_sum, acc_q[DATA_W-1:1]};
  assign div_shift = acc_q[2*DATA_W-1:DATA_W-1];
  assign div_ge    = div_shift >= {1'b0, mag_b_q};
  assign div_sub   = div_ge ? (div_shift - {1'b0, mag_b_q}) : div_shift;
  assign div_next  = {div_sub[DATA_W-1:0], acc_q[DATA_W-2:0], div_ge};

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    a_d      = a_q;
    mag_b_d  = mag_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    is_div_d = is_div_q;
    cnt_d    = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          state_d  = MD_BUSY;
          a_d      = a_i;
          mag_b_d  = mag_b;
          acc_d    = {{DATA_W{1'b0}}, mag_a};
          sa_d     = sa;
          sb_d     = sb;
          is_div_d = op_i[1];
          cnt_d    = CNT_W'(DATA_W);
        end else begin
          if (hi_we_i) hi_d = wdata_i;
          if (lo_we_i) lo_d = wdata_i;
        end
      end
      MD_BUSY: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = MD_DONE;
      end
      MD_DONE: begin
        state_d = MD_IDLE;
        if (!is_div_q) begin
          {hi_d, lo_d} = (sa_q ^ sb_q) ? -acc_q : acc_q;
        end else if (mag_b_q == '0) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          lo_d = (sa_q ^ sb_q) ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
          hi_d = sa_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= MD_IDLE;
      acc_q    <= '0;
      a_q      <= '0;
      mag_b_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      mag_b_q  <= mag_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      is_div_q <= is_div_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy_o = (state_q != MD_IDLE);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

`default_nettype wire

// File: rtl/ex_muldiv_stage.sv
// +--------------------------------------------------------------------------+
// | ex_muldiv_stage : EX stage with forwarding, ALU, mul/div and HI/LO  r1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

module ex_muldiv_stage
  import ex_muldiv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegDst_ex,
  input  logic              ALUSrcA_ex,
  input  logic              ALUSrcB_ex,
  input  logic [4:0]        ALUCode_ex,
  input  logic [DATA_W-1:0] Imm_ex,
  input  logic [DATA_W-1:0] Sa_ex,
  input  logic [REG_AW-1:0] RsAddr_ex,
  input  logic [REG_AW-1:0] RtAddr_ex,
  input  logic [REG_AW-1:0] RdAddr_ex,
  input  logic [DATA_W-1:0] RsData_ex,
  input  logic [DATA_W-1:0] RtData_ex,
  input  logic [DATA_W-1:0] ALUResult_mem,
  input  logic [DATA_W-1:0] RegWriteData_wb,
  input  logic [REG_AW-1:0] RegWriteAddr_mem,
  input  logic [REG_AW-1:0] RegWriteAddr_wb,
  input  logic              RegWrite_mem,
  input  logic              RegWrite_wb,
  input  logic              MdStart_ex,
  input  logic [1:0]        MdOp_ex,
  input  logic [1:0]        HiLoRead_ex,
  input  logic [1:0]        HiLoWrite_ex,
  output logic [REG_AW-1:0] RegWriteAddr_ex,
  output logic [DATA_W-1:0] ALUResult_ex,
  output logic [DATA_W-1:0] MemWriteData_ex,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  output logic              Stall_ex,
  output logic [DATA_W-1:0] Hi,
  output logic [DATA_W-1:0] Lo
);

  logic [DATA_W-1:0] fwd_a, fwd_b, alu_y;
  logic              mem_fwd_ok, wb_fwd_ok, md_busy, hazard_op;

  assign mem_fwd_ok = RegWrite_mem && (RegWriteAddr_mem != '0);
  assign wb_fwd_ok  = RegWrite_wb && (RegWriteAddr_wb != '0);

  // MEM is the younger producer, so it wins over WB.
  always_comb begin
    fwd_a = RsData_ex;
    if (mem_fwd_ok && (RegWriteAddr_mem == RsAddr_ex))     fwd_a = ALUResult_mem;
    else if (wb_fwd_ok && (RegWriteAddr_wb == RsAddr_ex))  fwd_a = RegWriteData_wb;
  end

  always_comb begin
    fwd_b = RtData_ex;
    if (mem_fwd_ok && (RegWriteAddr_mem == RtAddr_ex))     fwd_b = ALUResult_mem;
    else if (wb_fwd_ok && (RegWriteAddr_wb == RtAddr_ex))  fwd_b = RegWriteData_wb;
  end

  assign ALU_A           = ALUSrcA_ex ? Sa_ex : fwd_a;
  assign ALU_B           = ALUSrcB_ex ? Imm_ex : fwd_b;
  assign MemWriteData_ex = fwd_b;
  assign RegWriteAddr_ex = RegDst_ex ? RdAddr_ex : RtAddr_ex;

  ex_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i      (ALU_A),
    .b_i      (ALU_B),
    .code_i   (ALUCode_ex),
    .result_o (alu_y)
  );

  muldiv_iter #(.DATA_W(DATA_W)) u_muldiv (
    .clk_i   (clk),
    .rst_i   (reset),
    .start_i (MdStart_ex),
    .op_i    (md_op_e'(MdOp_ex)),
    .a_i     (fwd_a),
    .b_i     (fwd_b),
    .hi_we_i (HiLoWrite_ex == HILO_HI),
    .lo_we_i (HiLoWrite_ex == HILO_LO),
    .wdata_i (fwd_a),
    .busy_o  (md_busy),
    .hi_o    (Hi),
    .lo_o    (Lo)
  );

  assign hazard_op = MdStart_ex | (|HiLoRead_ex) | (|HiLoWrite_ex);
  assign Stall_ex  = hazard_op & md_busy;

  always_comb begin
    ALUResult_ex = alu_y;
    if (HiLoRead_ex == HILO_HI)      ALUResult_ex = Hi;
    else if (HiLoRead_ex == HILO_LO) ALUResult_ex = Lo;
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv_stage.sv
// +--------------------------------------------------------------------------+
// | tb_ex_muldiv_stage : scoreboard bench for the EX mul/div stage      r1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ex_muldiv_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          RegDst_ex, ALUSrcA_ex, ALUSrcB_ex;
  logic [4:0]    ALUCode_ex;
  logic [DW-1:0] Imm_ex, Sa_ex, RsData_ex, RtData_ex, ALUResult_mem, RegWriteData_wb;
  logic [AW-1:0] RsAddr_ex, RtAddr_ex, RdAddr_ex, RegWriteAddr_mem, RegWriteAddr_wb;
  logic          RegWrite_mem, RegWrite_wb, MdStart_ex;
  logic [1:0]    MdOp_ex, HiLoRead_ex, HiLoWrite_ex;
  logic [AW-1:0] RegWriteAddr_ex;
  logic [DW-1:0] ALUResult_ex, MemWriteData_ex, ALU_A, ALU_B, Hi, Lo;
  logic          Stall_ex;

  always #5 clk = ~clk;

  ex_muldiv_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .reset(reset),
    .RegDst_ex(RegDst_ex), .ALUSrcA_ex(ALUSrcA_ex), .ALUSrcB_ex(ALUSrcB_ex),
    .ALUCode_ex(ALUCode_ex), .Imm_ex(Imm_ex), .Sa_ex(Sa_ex),
    .RsAddr_ex(RsAddr_ex), .RtAddr_ex(RtAddr_ex), .RdAddr_ex(RdAddr_ex),
    .RsData_ex(RsData_ex), .RtData_ex(RtData_ex),
    .ALUResult_mem(ALUResult_mem), .RegWriteData_wb(RegWriteData_wb),
    .RegWriteAddr_mem(RegWriteAddr_mem), .RegWriteAddr_wb(RegWriteAddr_wb),
    .RegWrite_mem(RegWrite_mem), .RegWrite_wb(RegWrite_wb),
    .MdStart_ex(MdStart_ex), .MdOp_ex(MdOp_ex),
    .HiLoRead_ex(HiLoRead_ex), .HiLoWrite_ex(HiLoWrite_ex),
    .RegWriteAddr_ex(RegWriteAddr_ex), .ALUResult_ex(ALUResult_ex),
    .MemWriteData_ex(MemWriteData_ex), .ALU_A(ALU_A), .ALU_B(ALU_B),
    .Stall_ex(Stall_ex), .Hi(Hi), .Lo(Lo)
  );

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    RegDst_ex = 0; ALUSrcA_ex = 0; ALUSrcB_ex = 0; ALUCode_ex = '0;
    Imm_ex = '0; Sa_ex = '0; RsData_ex = '0; RtData_ex = '0;
    ALUResult_mem = '0; RegWriteData_wb = '0;
    RsAddr_ex = '0; RtAddr_ex = '0; RdAddr_ex = '0;
    RegWriteAddr_mem = '0; RegWriteAddr_wb = '0;
    RegWrite_mem = 0; RegWrite_wb = 0;
    MdStart_ex = 0; MdOp_ex = '0; HiLoRead_ex = '0; HiLoWrite_ex = '0;
  endtask

  task automatic md_model(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          output logic [DW-1:0] hi, output logic [DW-1:0] lo);
    longint     sa, sb, p;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      2'd1: begin u = {32'd0, a} * {32'd0, b}; hi = u[63:32]; lo = u[31:0]; end
      2'd2: begin
        if (b == '0) begin hi = a; lo = '1; end
        else begin p = sa / sb; lo = p[31:0]; p = sa % sb; hi = p[31:0]; end
      end
      default: begin
        if (b == '0) begin hi = a; lo = '1; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endtask

  task automatic wait_stall(output int cyc);
    cyc = 0;
    while (Stall_ex === 1'b1 && cyc < 200) begin
      tick;
      cyc++;
    end
  endtask

  // Issue one mul/div, then MFHI (stalls until done) and MFLO; results come off the scoreboard.
  task automatic run_md(input string tag, input logic [1:0] op,
                        input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] h, l;
    int            cyc;
    idle_in;
    RsAddr_ex = 5'd1; RtAddr_ex = 5'd2; RsData_ex = a; RtData_ex = b;
    MdStart_ex = 1; MdOp_ex = op;
    #1 chk({tag, " start_nostall"}, Stall_ex, 0);
    md_model(op, a, b, h, l);
    exp_q.push_back(h);
    exp_q.push_back(l);
    tick;
    MdStart_ex = 0; HiLoRead_ex = 2'b01;
    #1 wait_stall(cyc);
    chk({tag, " mfhi_stall_cycles"}, cyc, DW + 1);
    chk({tag, " mfhi"}, ALUResult_ex, exp_q.pop_front());
    tick;
    HiLoRead_ex = 2'b10;
    #1 chk({tag, " mflo"}, ALUResult_ex, exp_q.pop_front());
    tick;
    idle_in;
  endtask

  initial begin
    int cyc;
    idle_in;
    reset = 1;
    repeat (2) tick;
    reset = 0;
    #1;
    chk("reset Hi", Hi, 0);
    chk("reset Lo", Lo, 0);
    chk("reset Stall", Stall_ex, 0);

    // Forwarding priority and r0 exclusion
    RsAddr_ex = 5'd5; RsData_ex = 32'h33;
    RegWrite_mem = 1; RegWriteAddr_mem = 5'd5; ALUResult_mem = 32'h11;
    RegWrite_wb = 1;  RegWriteAddr_wb = 5'd5;  RegWriteData_wb = 32'h22;
    #1 chk("fwd mem_over_wb", ALU_A, 32'h11);
    RegWrite_mem = 0;
    #1 chk("fwd wb", ALU_A, 32'h22);
    RegWrite_mem = 1; RsAddr_ex = '0; RegWriteAddr_mem = '0; RegWriteAddr_wb = '0;
    #1 chk("fwd r0", ALU_A, 32'h33);
    RtAddr_ex = 5'd9; RtData_ex = 32'h66; RegWriteAddr_mem = 5'd9; RegWrite_mem = 0;
    RegWriteAddr_wb = 5'd9; RegWriteData_wb = 32'h55;
    #1 chk("fwd B wb", MemWriteData_ex, 32'h55);
    RegDst_ex = 1; RdAddr_ex = 5'd17;
    #1 chk("regdst rd", RegWriteAddr_ex, 5'd17);
    RegDst_ex = 0;
    #1 chk("regdst rt", RegWriteAddr_ex, 5'd9);
    ALUSrcB_ex = 1; Imm_ex = 32'd7; ALUSrcA_ex = 1; Sa_ex = 32'd5; ALUCode_ex = 5'd0;
    #1 chk("alu add imm", ALUResult_ex, 32'd12);
    tick;
    idle_in;

    // MTHI in IDLE
    HiLoWrite_ex = 2'b01; RsAddr_ex = 5'd3; RsData_ex = 32'h1234;
    #1 chk("mthi no_stall", Stall_ex, 0);
    tick;
    idle_in;
    chk("mthi Hi", Hi, 32'h1234);

    run_md("mult -3x7", 2'd0, 32'hFFFF_FFFD, 32'd7);
    run_md("div -7/2", 2'd2, 32'hFFFF_FFF9, 32'd2);
    run_md("divu 7/0", 2'd3, 32'd7, 32'd0);
    run_md("div -5/0", 2'd2, 32'hFFFF_FFFB, 32'd0);
    run_md("div min/-1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_md("multu max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) begin
      run_md("rand", 2'(i), $urandom, $urandom_range(1, 32'hFFFF));
    end

    // MTLO with forwarded operand held back during a MULT
    idle_in;
    RsData_ex = 32'd2; RtData_ex = 32'd3; MdStart_ex = 1; MdOp_ex = 2'd0;
    tick;
    idle_in;
    HiLoWrite_ex = 2'b10; RsAddr_ex = 5'd7; RsData_ex = 32'h0;
    RegWrite_mem = 1; RegWriteAddr_mem = 5'd7; ALUResult_mem = 32'hABCD;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hABCD);
    #1 wait_stall(cyc);
    chk("mtlo stall_cycles", cyc, DW + 1);
    tick;
    idle_in;
    chk("mtlo Hi", Hi, exp_q.pop_front());
    chk("mtlo Lo", Lo, exp_q.pop_front());

    // Reset in the middle of a DIV
    RsData_ex = 32'd100; RtData_ex = 32'd3; MdStart_ex = 1; MdOp_ex = 2'd2;
    tick;
    MdStart_ex = 0; HiLoRead_ex = 2'b01;
    repeat (9) tick;
    chk("pre_reset stall", Stall_ex, 1);
    reset = 1;
    tick;
    reset = 0;
    #1;
    chk("mid_reset Stall", Stall_ex, 0);
    chk("mid_reset Hi", Hi, 0);
    chk("mid_reset Lo", Lo, 0);
    run_md("post_reset mult 2x3", 2'd0, 32'd2, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
